// File: rtl/fb_stream_writer.sv
// Packs a start-of-frame delimited byte stream into 20-bit framebuffer words,
// writes them sequentially into the back buffer and swaps buffers on a display frame boundary.
module fb_stream_writer #(
    parameter int DATA_W      = 20,
    parameter int ADDR_W      = 14,
    parameter int FRAME_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic              frame_boundary,
    output logic [DATA_W-1:0] fb_wdata,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic              fb_we,
    output logic              selection,
    output logic              frame_done,
    output logic              sync_err
);

    localparam logic [1:0] HUNT      = 2'd0;
    localparam logic [1:0] FILL      = 2'd1;
    localparam logic [1:0] SWAP_WAIT = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

    logic [1:0]        state;
    logic [1:0]        byte_idx;
    logic [7:0]        byte0;
    logic [7:0]        byte1;
    logic [ADDR_W-1:0] word_cnt;
    logic              accept;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            byte_idx   <= '0;
            byte0      <= '0;
            byte1      <= '0;
            word_cnt   <= '0;
            in_ready   <= 1'b0;
            fb_we      <= 1'b0;
            fb_wdata   <= '0;
            fb_waddr   <= '0;
            selection  <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            // in_ready tracks the registered state; transitions into/out of SWAP_WAIT override it below
            in_ready   <= (state != SWAP_WAIT);

            case (state)
                HUNT: begin
                    if (accept && in_sof) begin
                        byte0    <= in_data;
                        byte_idx <= 2'd1;
                        word_cnt <= '0;
                        state    <= FILL;
                    end
                end

                FILL: begin
                    if (accept) begin
                        if (in_sof && (byte_idx != 2'd0 || word_cnt != '0)) begin
                            sync_err <= 1'b1;
                            byte0    <= in_data;
                            byte_idx <= 2'd1;
                            word_cnt <= '0;
                        end else begin
                            case (byte_idx)
                                2'd0: begin
                                    byte0    <= in_data;
                                    byte_idx <= 2'd1;
                                end
                                2'd1: begin
                                    byte1    <= in_data;
                                    byte_idx <= 2'd2;
                                end
                                default: begin
                                    // upper nibble of the third byte has no slot in the 20-bit word
                                    fb_we    <= 1'b1;
                                    fb_wdata <= DATA_W'({in_data[3:0], byte1, byte0});
                                    fb_waddr <= word_cnt;
                                    byte_idx <= 2'd0;
                                    if (word_cnt == LAST_WORD) begin
                                        word_cnt <= '0;
                                        state    <= SWAP_WAIT;
                                        in_ready <= 1'b0;
                                    end else begin
                                        word_cnt <= word_cnt + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end

                SWAP_WAIT: begin
                    if (frame_boundary) begin
                        selection  <= ~selection;
                        frame_done <= 1'b1;
                        byte_idx   <= '0;
                        word_cnt   <= '0;
                        state      <= HUNT;
                        in_ready   <= 1'b1;
                    end
                end

                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_stream_writer.sv
// Bench for fb_stream_writer: table-driven packing vectors, write scoreboard,
// hand-written sequences for swap, resync, reset and the single-word frame case.
module tb_fb_stream_writer;

    localparam int DW = 20;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          frame_boundary = 1'b0;

    logic          in_ready, fb_we, selection, frame_done, sync_err;
    logic [DW-1:0] fb_wdata;
    logic [AW-1:0] fb_waddr;

    logic          in_ready_1, fb_we_1, selection_1, frame_done_1, sync_err_1;
    logic [DW-1:0] fb_wdata_1;
    logic [AW-1:0] fb_waddr_1;

    fb_stream_writer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_WORDS(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .frame_boundary(frame_boundary), .fb_wdata(fb_wdata),
        .fb_waddr(fb_waddr), .fb_we(fb_we), .selection(selection),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    fb_stream_writer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_WORDS(1)) dut_1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready_1), .frame_boundary(frame_boundary), .fb_wdata(fb_wdata_1),
        .fb_waddr(fb_waddr_1), .fb_we(fb_we_1), .selection(selection_1),
        .frame_done(frame_done_1), .sync_err(sync_err_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    b0;
        logic [7:0]    b1;
        logic [7:0]    b2;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    vec_t tbl [4];
    wr_t  exp_q [$];
    int   tests = 0;
    int   fails = 0;
    int   fd_cnt = 0;
    int   sel_cnt = 0;
    logic sel_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle; scoreboard the write port and count pulses on the way
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (fb_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", fb_waddr, fb_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(fb_waddr), 32'(e.addr));
                chk("wr_data", 32'(fb_wdata), 32'(e.data));
            end
        end
        if (frame_done) fd_cnt++;
        if (selection !== sel_prev) sel_cnt++;
        sel_prev = selection;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        int unsigned n = 0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic sof, input logic [AW-1:0] addr, input logic [DW-1:0] expd);
        send(b0, sof);
        send(b1, 1'b0);
        exp_q.push_back('{addr: addr, data: expd});
        send(b2, 1'b0);
        chk("pack_we", 32'(fb_we), 32'd1);
    endtask

    task automatic pulse_fb();
        frame_boundary = 1'b1;
        tick();
        frame_boundary = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_fb_we",      32'(fb_we),      32'd0);
        chk("rst_fb_wdata",   32'(fb_wdata),   32'd0);
        chk("rst_fb_waddr",   32'(fb_waddr),   32'd0);
        chk("rst_selection",  32'(selection),  32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_sync_err",   32'(sync_err),   32'd0);
    endtask

    initial begin
        int fd0;
        int s0;
        logic [7:0] rb [3];

        tbl[0] = '{b0: 8'h11, b1: 8'h22, b2: 8'hA3, exp: 20'h32211};
        tbl[1] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, exp: 20'h00000};
        tbl[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, exp: 20'hFFFFF};
        tbl[3] = '{b0: 8'h34, b1: 8'h12, b2: 8'hF5, exp: 20'h51234};

        repeat (3) tick();
        chk_reset_vals();
        rst = 1'b1;
        tick();
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Bytes before any SOF are discarded
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        tick();
        chk("hunt_no_write", 32'(fb_we), 32'd0);

        for (int i = 0; i < 4; i++)
            send_word(tbl[i].b0, tbl[i].b1, tbl[i].b2, i == 0, AW'(i), tbl[i].exp);
        chk("swap_wait_ready", 32'(in_ready), 32'd0);

        // Offered bytes must be refused while waiting for the boundary
        fd0 = fd_cnt;
        in_data = 8'hEE; in_sof = 1'b1; in_valid = 1'b1;
        repeat (50) tick();
        in_valid = 1'b0; in_sof = 1'b0;
        chk("hold_selection", 32'(selection), 32'd0);
        chk("hold_no_done", 32'(fd_cnt), 32'(fd0));
        chk("hold_ready", 32'(in_ready), 32'd0);
        pulse_fb();
        chk("swap_selection", 32'(selection), 32'd1);
        chk("swap_done", 32'(frame_done), 32'd1);
        tick();
        chk("swap_done_1cyc", 32'(frame_done), 32'd0);
        chk("swap_ready", 32'(in_ready), 32'd1);

        // Boundary during FILL is ignored; mid-frame SOF restarts the frame
        fd0 = fd_cnt;
        send(8'h01, 1'b1);
        pulse_fb();
        chk("fill_fb_sel", 32'(selection), 32'd1);
        chk("fill_fb_done", 32'(fd_cnt), 32'(fd0));
        send(8'h02, 1'b0);
        exp_q.push_back('{addr: AW'(0), data: 20'h30201});
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        send(8'h66, 1'b1);
        chk("sync_err", 32'(sync_err), 32'd1);
        tick();
        chk("sync_err_1cyc", 32'(sync_err), 32'd0);
        send(8'h77, 1'b0);
        exp_q.push_back('{addr: AW'(0), data: 20'h87766});
        send(8'h88, 1'b0);
        send_word(8'hA0, 8'hB1, 8'hC2, 1'b0, AW'(1), 20'h2B1A0);
        send_word(8'h0F, 8'hF0, 8'h3C, 1'b0, AW'(2), 20'hCF00F);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        exp_q.push_back('{addr: AW'(3), data: 20'h63412});
        frame_boundary = 1'b1;
        send(8'h56, 1'b0);
        frame_boundary = 1'b0;
        repeat (3) tick();
        chk("entry_fb_sel", 32'(selection), 32'd1);
        chk("entry_fb_ready", 32'(in_ready), 32'd0);
        chk("entry_fb_done", 32'(fd_cnt), 32'(fd0));
        pulse_fb();
        chk("swap2_selection", 32'(selection), 32'd0);
        chk("swap2_done", 32'(frame_done), 32'd1);

        // Two frames of random bytes with random input gaps
        s0 = sel_cnt;
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < 4; w++) begin
                for (int k = 0; k < 3; k++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    rb[k] = 8'($urandom);
                    if (k == 2)
                        exp_q.push_back('{addr: AW'(w), data: {rb[2][3:0], rb[1], rb[0]}});
                    send(rb[k], (k == 0) && (w == 0));
                end
            end
            repeat ($urandom_range(0, 5)) tick();
            pulse_fb();
        end
        tick();
        chk("rand_sel_toggles", 32'(sel_cnt - s0), 32'd2);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame with selection=1
        for (int i = 0; i < 4; i++)
            send_word(tbl[i].b0, tbl[i].b1, tbl[i].b2, i == 0, AW'(i), tbl[i].exp);
        pulse_fb();
        chk("pre_rst_sel", 32'(selection), 32'd1);
        send(8'h99, 1'b1);
        send(8'h98, 1'b0);
        rst = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rst = 1'b1;
        tick();
        chk("ready_after_rst2", 32'(in_ready), 32'd1);

        // Single-word frame instance swaps after its first word
        send(8'h21, 1'b1);
        send(8'h43, 1'b0);
        exp_q.push_back('{addr: AW'(0), data: 20'h54321});
        send(8'h65, 1'b0);
        chk("fw1_we", 32'(fb_we_1), 32'd1);
        chk("fw1_waddr", 32'(fb_waddr_1), 32'd0);
        chk("fw1_wdata", 32'(fb_wdata_1), 32'h54321);
        tick();
        chk("fw1_ready", 32'(in_ready_1), 32'd0);
        chk("fw4_ready", 32'(in_ready), 32'd1);
        pulse_fb();
        chk("fw1_selection", 32'(selection_1), 32'd1);
        chk("fw1_done", 32'(frame_done_1), 32'd1);
        chk("fw1_sync_err", 32'(sync_err_1), 32'd0);
        chk("fw4_selection", 32'(selection), 32'd0);

        tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
